// File: rtl/sap_1_controller_sequencer_if.sv
// sap_1_controller_sequencer_if: opcode in, control word / ring state / halt out.
//   Opcode : IR upper nibble, into the sequencer
//   Con    : 12-bit control word {Cp,Ep,LmBar,CeBar,LiBar,EiBar,LaBar,Ea,Su,Eu,LbBar,LoBar}
//   T      : one-hot ring state, T[0]=T1 .. T[5]=T6
//   Hlt    : high while halted
interface sap_1_controller_sequencer_if;
    logic [3:0]  Opcode;
    logic [11:0] Con;
    logic [5:0]  T;
    logic        Hlt;
    modport master (input Opcode, output Con, output T, output Hlt);
    modport slave  (output Opcode, input Con, input T, input Hlt);
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 six-state ring counter plus control matrix.
//   ClkN : system clock, state changes on its falling edge
//   Clr  : asynchronous active-high reset, returns to T1
//   bus  : master side of sap_1_controller_sequencer_if (Opcode in; Con, T, Hlt out)
// Optional HLT support is compiled in with SAP_1_CONTROLLER_HLT_EN.
module sap_1_controller_sequencer #(
    parameter logic [3:0] HLT_OPCODE = 4'b1111
) (
    input logic ClkN,
    input logic Clr,
    sap_1_controller_sequencer_if.master bus
);
    localparam logic [11:0] NOP = 12'h3E3;
    typedef enum logic {RUN, HALT} mode_t;
    mode_t       mode;
    logic [5:0]  ring;
    logic        halt_hit;
    logic [11:0] con;
    logic        is_lda, is_add, is_sub, is_out;
    assign is_lda = bus.Opcode == 4'b0000;
    assign is_add = bus.Opcode == 4'b0001;
    assign is_sub = bus.Opcode == 4'b0010;
    assign is_out = bus.Opcode == 4'b1110;
`ifdef SAP_1_CONTROLLER_HLT_EN
    assign halt_hit = ring == 6'b001000 && bus.Opcode == HLT_OPCODE;
`else
    logic unused_hlt_opcode;
    assign unused_hlt_opcode = ^HLT_OPCODE;
    assign halt_hit = 1'b0;
`endif
    // A non-one-hot ring (e.g. X at power-up) is forced back to T1.
    always_ff @(negedge ClkN or posedge Clr)
        if (Clr) begin
            ring <= 6'b000001;
            mode <= RUN;
        end else if (mode == RUN) begin
            if (halt_hit) mode <= HALT;
            else ring <= $onehot(ring) ? {ring[4:0], ring[5]} : 6'b000001;
        end
    always_comb begin
        con = mode == HALT ? NOP :
              ring[0] ? 12'h5E3 :
              ring[1] ? 12'hBE3 :
              ring[2] ? 12'h263 :
              ring[3] ? (is_lda || is_add || is_sub ? 12'h1A3 : is_out ? 12'h3F2 : NOP) :
              ring[4] ? (is_lda ? 12'h2C3 : is_add || is_sub ? 12'h2E1 : NOP) :
              ring[5] ? (is_add ? 12'h3C7 : is_sub ? 12'h3CF : NOP) : NOP;
    end
    assign bus.Con = con;
    assign bus.T   = ring;
    assign bus.Hlt = mode == HALT;
endmodule
